// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Owns the fetch PC, drives instruction memory over a req/ack handshake and
// buffers fetched {pc, instr} pairs in a small FIFO toward decode, so memory
// traffic is decoupled from decode stalls. cpu_ctrl steers fetch through
// redirect_i (flush + new PC) and halt_i (stop issuing requests).
//
// Optional build macro: IF_MISALIGN_CHECK_EN
//   defined   : a redirect target with bits[1:0] != 0 raises the sticky
//               error_o and parks the stage in S_HALT until rst.
//   undefined : the low target bits are dropped silently, error_o is 0.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_req_o      fetch request (forced low while rst is high)
//   imem_addr_o     word-aligned fetch address
//   imem_ack_i      memory completes the transfer this cycle (req & ack)
//   imem_rdata_i    instruction word for a completed transfer
//   id_ready_i      decode consumes the head entry this cycle
//   valid_o         head entry valid
//   instr_o, pc_o   head entry (NOP / 0 when empty)
//   redirect_i      redirect request, redirect_pc_i is the target
//   halt_i          stop-fetch request
//   error_o         sticky misaligned-redirect fault
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,

    input  logic        id_ready_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        error_o
);

    localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    state_e                        state_q;
    logic                          error_q;
    logic [31:0]                   fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    fetch_entry_t [FIFO_DEPTH-1:0] fifo_q;

    logic         full;
    logic         push;
    logic         pop;
    logic         misalign;
    fetch_entry_t head;

    // -------------------------------------------------------------------------
    // Misaligned redirect detection
    // -------------------------------------------------------------------------
`ifdef IF_MISALIGN_CHECK_EN
    assign misalign = redirect_i & (|redirect_pc_i[1:0]);
    assign error_o  = error_q;
`else
    // Low target bits are intentionally discarded in this build.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
    assign misalign            = 1'b0;
    assign error_o             = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Memory request side
    // -------------------------------------------------------------------------
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));

    // Redirect and halt kill the request in the same cycle, so an ack that
    // arrives alongside either can never produce a push.
    assign imem_req_o  = ~rst & (state_q == S_RUN) & ~full & ~redirect_i & ~halt_i;
    assign imem_addr_o = {fetch_pc_q[31:2], 2'b00};

    assign push        = imem_req_o & imem_ack_i;
    assign pop         = valid_o & id_ready_i & ~redirect_i;

    // -------------------------------------------------------------------------
    // Decode side
    // -------------------------------------------------------------------------
    assign head    = fifo_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign instr_o = valid_o ? head.instr : NOP;
    assign pc_o    = valid_o ? head.pc    : 32'h0;

    // -------------------------------------------------------------------------
    // Next-state for PC and FIFO bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_i) begin
            // Flush overrides any pop or ack seen this cycle.
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count_q != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_rdata_i};
        end
    end

    // -------------------------------------------------------------------------
    // Run/halt control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            error_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (misalign) begin
                        state_q <= S_HALT;
                        error_q <= 1'b1;
                    end else if (halt_i) begin
                        // Covers redirect+halt: redirect still lands on the PC.
                        state_q <= S_HALT;
                    end
                end
                S_HALT: begin
                    // A raised fault pins the stage here until reset.
                    if (!error_q) begin
                        if (misalign) begin
                            error_q <= 1'b1;
                        end else if (redirect_i && !halt_i) begin
                            state_q <= S_RUN;
                        end
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage; sits directly upstream of the decode stage and supplies it with {instr, pc} pairs.
- Owns the fetch PC and drives the instruction memory through a req/ack handshake.
- Buffers fetched words in a small FIFO so the memory is decoupled from decode stalls.
- Takes PC redirects and halts from cpu_ctrl.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 2, entries of {pc, instr} buffered toward decode (power of two, >=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (word aligned)
imem_ack_i  in  1  memory accepts and returns data this cycle
imem_rdata_i  in  32  instruction word, valid when imem_req_o & imem_ack_i
id_ready_i  in  1  decode consumes head entry this cycle
valid_o  out  1  head entry valid
instr_o  out  32  head instruction
pc_o  out  32  head PC
redirect_i  in  1  branch/jump/exception redirect
redirect_pc_i  in  32  redirect target
halt_i  in  1  cpu_ctrl stop-fetch request
error_o  out  1  sticky fetch fault (see Optional Feature)

Behaviour:
- Reset (rst high at a clock edge):
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=S_RUN, error_o=0.
  - imem_req_o is forced 0 combinationally while rst=1.
- State machine:
  - S_RUN: fetches. Moves to S_HALT on halt_i=1, or on fault when the feature is enabled.
  - S_HALT: no requests. Leaves only on redirect_i=1 (to S_RUN), unless error_o=1; once error_o=1, only rst exits.
- Request rule: imem_req_o = (state==S_RUN) & (count<FIFO_DEPTH) & ~redirect_i & ~halt_i.
- Address: imem_addr_o = {fetch_pc[31:2],2'b00}.
- Memory handshake:
  - Transfer completes in a cycle with req & ack both high; zero-wait (same-cycle) ack is legal.
  - req may drop before ack (abort); the memory must not ack an aborted request later.
  - One request outstanding at most.
- On a completed transfer:
  - Push {fetch_pc, imem_rdata_i} into the FIFO.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
- Decode interface:
  - valid_o = (count!=0).
  - instr_o/pc_o = head entry when valid_o=1; otherwise instr_o=32'h0000_0013 (NOP) and pc_o=32'h0.
  - Pop when valid_o & id_ready_i.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: no request is issued, so no push can occur. A pop in that cycle re-enables req next cycle.
- Empty: a pop is ignored (id_ready_i is don't-care).
- Redirect (highest priority over everything except rst):
  - FIFO is flushed: count=0, pointers=0.
  - fetch_pc <= redirect_pc_i with bits[1:0] cleared.
  - Any ack or pop in the same cycle is discarded.
  - First request to the new PC occurs the next cycle, so redirect-to-valid_o latency is 2 cycles with zero-wait memory.
- halt_i:
  - Suppresses req the same cycle.
  - The FIFO is not flushed and continues to drain to decode.
- redirect_i and halt_i together: redirect is applied (PC loaded, FIFO flushed), then state=S_HALT.
- Latency (zero-wait memory): fetch at cycle N gives valid_o=1 at cycle N+1. Sustained throughput is 1 instr/cycle while id_ready_i=1.

Optional Feature:
Macro: IF_MISALIGN_CHECK_EN
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 sets error_o=1 (sticky until rst) and enters S_HALT.
  - No further requests are issued; the FIFO is flushed as for any redirect.
- Undefined:
  - redirect_pc_i[1:0] is silently cleared.
  - error_o is tied 0 and S_HALT is reachable only via halt_i.

Test Plan:
1. Reset, then release with RESET_PC=32'h0000_0000, ack always 1, id_ready_i=1: addresses 0x0, 0x4, 0x8 on consecutive cycles; valid_o=1 from cycle 2 with pc_o 0x0, 0x4, 0x8 and matching instr_o.
2. id_ready_i=0 for 6 cycles, ack=1: exactly FIFO_DEPTH=2 pushes, then imem_req_o=0. Raising id_ready_i yields pc_o 0x0 then 0x4 with no gaps; req resumes the cycle after the first pop.
3. Redirect to 32'h0000_0100 while the FIFO holds 2 entries and ack=1 that cycle: the acked word is dropped, valid_o=0 next cycle, next imem_addr_o=0x100, valid_o=1 with pc_o=0x100 two cycles after redirect.
4. Memory with 3-cycle ack delay: imem_addr_o stays stable until ack; one push per ack; no duplicate or skipped PC.
5. halt_i=1 with 2 entries buffered: req=0 immediately, both entries still delivered. Redirect to 0x200 then resumes fetching at 0x200.
6. With IF_MISALIGN_CHECK_EN defined, redirect to 0x102: error_o=1 next cycle, req stays 0 for 10 cycles, valid_o=0. Without the macro: fetch resumes at 0x100 and error_o=0.
